// File: rtl/uart_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_pkg
// Brief    : Shared state encoding, header field positions and widths for the
//            UART register bridge.
// Revision : 1.0 - initial release
// ============================================================================
package uart_reg_pkg;

    localparam int REG_ADDR_W   = 6;
    localparam int BURST_W      = 9;

    localparam int HDR_WR       = 7;
    localparam int HDR_INC      = 6;
    localparam int HDR_ADDR_MSB = 5;
    localparam int HDR_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        WDATA = 3'd2,
        RREQ  = 3'd3,
        RWAIT = 3'd4,
        RSEND = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_reg_timeout.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_timeout
// Brief    : Saturating idle counter; o_expired is high once TIMEOUT_CYCLES-1
//            cycles have elapsed since the last i_clear.
// Revision : 1.0 - initial release
// ============================================================================
module uart_reg_timeout #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_expired
);

    localparam int              CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != C_LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_bridge
// Brief    : Turns host UART packets {wr,inc,addr},count,[data] into register
//            requests and returns read data over the UART TX byte interface.
//            Optional packet timeout: define UART_REG_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_reg_bridge
    import uart_reg_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic [5:0] reg_addr,
    output logic       write,
    output logic       new_req,
    output logic [7:0] write_value,
    input  logic [7:0] read_value,
    output logic       busy
);

    localparam logic [3:0] C_READ_LATENCY = 4'(READ_LATENCY);

    state_t                  r_state, w_state_next;
    logic                    r_wr, w_wr_next;
    logic                    r_inc, w_inc_next;
    logic [REG_ADDR_W-1:0]   r_addr, w_addr_next, w_addr_adv;
    logic [BURST_W-1:0]      r_remaining, w_remaining_next;
    logic [3:0]              r_wait, w_wait_next;
    logic [7:0]              r_hold, w_hold_next;
    logic [7:0]              r_tx_data, w_tx_data_next;
    logic                    r_new_tx_data, w_new_tx_data_next;
    logic [REG_ADDR_W-1:0]   r_reg_addr, w_reg_addr_next;
    logic                    r_write, w_write_next;
    logic                    r_new_req, w_new_req_next;
    logic [7:0]              r_write_value, w_write_value_next;
    logic                    r_busy;
    logic                    w_timeout;
    logic                    w_last;

    assign w_addr_adv = r_inc ? r_addr + 1'b1 : r_addr;
    assign w_last     = (r_remaining == BURST_W'(1));

`ifdef UART_REG_TIMEOUT_EN
    logic w_timeout_clear;

    assign w_timeout_clear = new_rx_data | (w_state_next != r_state);

    uart_reg_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timeout_clear),
        .o_expired (w_timeout)
    );
`else
    // Timeout disabled: never fires for any legal parameter value
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_wr          <= 1'b0;
            r_inc         <= 1'b0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_wait        <= '0;
            r_hold        <= '0;
            r_tx_data     <= '0;
            r_new_tx_data <= 1'b0;
            r_reg_addr    <= '0;
            r_write       <= 1'b0;
            r_new_req     <= 1'b0;
            r_write_value <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wr          <= w_wr_next;
            r_inc         <= w_inc_next;
            r_addr        <= w_addr_next;
            r_remaining   <= w_remaining_next;
            r_wait        <= w_wait_next;
            r_hold        <= w_hold_next;
            r_tx_data     <= w_tx_data_next;
            r_new_tx_data <= w_new_tx_data_next;
            r_reg_addr    <= w_reg_addr_next;
            r_write       <= w_write_next;
            r_new_req     <= w_new_req_next;
            r_write_value <= w_write_value_next;
            r_busy        <= (w_state_next != IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (new_rx_data) w_state_next = COUNT;
            end
            COUNT: begin
                if (new_rx_data)    w_state_next = r_wr ? WDATA : RREQ;
                else if (w_timeout) w_state_next = IDLE;
            end
            WDATA: begin
                if (new_rx_data) begin
                    if (w_last) w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            RREQ:  w_state_next = RWAIT;
            RWAIT: begin
                if (r_wait == 4'd1) w_state_next = RSEND;
            end
            RSEND: begin
                if (!tx_busy) w_state_next = w_last ? IDLE : RREQ;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Read requests are registered on entry to RREQ so new_req is high
    // during the RREQ cycle itself.
    always_comb begin
        w_wr_next          = r_wr;
        w_inc_next         = r_inc;
        w_addr_next        = r_addr;
        w_remaining_next   = r_remaining;
        w_wait_next        = r_wait;
        w_hold_next        = r_hold;
        w_tx_data_next     = r_tx_data;
        w_new_tx_data_next = 1'b0;
        w_reg_addr_next    = r_reg_addr;
        w_write_next       = r_write;
        w_new_req_next     = 1'b0;
        w_write_value_next = r_write_value;
        case (r_state)
            IDLE: begin
                if (new_rx_data) begin
                    w_wr_next   = rx_data[HDR_WR];
                    w_inc_next  = rx_data[HDR_INC];
                    w_addr_next = rx_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
                end
            end
            COUNT: begin
                if (new_rx_data) begin
                    w_remaining_next = {1'b0, rx_data} + BURST_W'(1);
                    if (!r_wr) begin
                        w_new_req_next  = 1'b1;
                        w_write_next    = 1'b0;
                        w_reg_addr_next = r_addr;
                    end
                end
            end
            WDATA: begin
                if (new_rx_data) begin
                    w_new_req_next     = 1'b1;
                    w_write_next       = 1'b1;
                    w_reg_addr_next    = r_addr;
                    w_write_value_next = rx_data;
                    w_addr_next        = w_addr_adv;
                    w_remaining_next   = r_remaining - BURST_W'(1);
                end
            end
            RREQ: begin
                w_wait_next = C_READ_LATENCY;
            end
            RWAIT: begin
                w_wait_next = r_wait - 4'd1;
                if (r_wait == 4'd1) w_hold_next = read_value;
            end
            RSEND: begin
                if (!tx_busy) begin
                    w_new_tx_data_next = 1'b1;
                    w_tx_data_next     = r_hold;
                    w_addr_next        = w_addr_adv;
                    w_remaining_next   = r_remaining - BURST_W'(1);
                    if (!w_last) begin
                        w_new_req_next  = 1'b1;
                        w_write_next    = 1'b0;
                        w_reg_addr_next = w_addr_adv;
                    end
                end
            end
            default: ;
        endcase
    end

    assign tx_data     = r_tx_data;
    assign new_tx_data = r_new_tx_data;
    assign reg_addr    = r_reg_addr;
    assign write       = r_write;
    assign new_req     = r_new_req;
    assign write_value = r_write_value;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Upstream of the register controller: turns the UART byte stream from the host into register requests (reg_addr/write/new_req/write_value).
- Returns register read data to the host over the UART TX byte interface.
- Supports burst transfers of 1..256 bytes with optional address auto-increment over the 6-bit register space.

Parameters:
- READ_LATENCY, 1, cycles from a new_req read pulse to valid read_value (range 1..15).
- TIMEOUT_CYCLES, 5000000, idle cycles before a partial packet is aborted (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received UART byte
- new_rx_data  in  1  one-cycle strobe; rx_data valid
- tx_data  out  8  byte to transmit
- new_tx_data  out  1  one-cycle strobe; tx_data valid
- tx_busy  in  1  transmitter busy; no new_tx_data while high
- reg_addr  out  6  register address
- write  out  1  1 = write request, 0 = read request
- new_req  out  1  one-cycle request strobe
- write_value  out  8  write data
- read_value  in  8  register read data, valid READ_LATENCY cycles after the read new_req
- busy  out  1  high whenever state != IDLE

Behaviour:
- Packet format:
  - Header byte {wr, inc, addr[5:0]}.
  - Count byte C; burst length N = C+1.
  - For writes, N data bytes follow; reads have no payload.
- All outputs are registered. Reset values: tx_data=0, new_tx_data=0, reg_addr=0, write=0, new_req=0, write_value=0, busy=0, state=IDLE.
- States and transitions:
  - IDLE: on new_rx_data, latch wr/inc/addr, go to COUNT.
  - COUNT: on new_rx_data, remaining=C+1 (9-bit). If wr, go to WDATA; else go to RREQ.
  - WDATA: on each new_rx_data, the next cycle drives new_req=1, write=1, reg_addr=addr, write_value=rx_data. Then addr advances (if inc) and remaining decrements. When remaining hits 0, go to IDLE.
  - RREQ: one cycle with new_req=1, write=0, reg_addr=addr. Load wait counter with READ_LATENCY, go to RWAIT.
  - RWAIT: decrement the counter each cycle. At 0, capture read_value into a holding register, go to RSEND.
  - RSEND: wait for tx_busy==0, then pulse new_tx_data=1 with tx_data=held byte. Advance addr (if inc), decrement remaining. If remaining==0 go to IDLE, else go to RREQ.
- Address rules:
  - Auto-increment wraps 6'h3F -> 6'h00.
  - With inc=0 every access targets the header address.
- Strobe rules:
  - new_req and new_tx_data are never high for more than one consecutive cycle.
  - write holds its last value between requests.
- Read-burst RX rule: bytes arriving in RREQ/RWAIT/RSEND are discarded; the bridge never buffers host bytes.
- tx_busy rule: tx_busy is sampled in RSEND only. new_tx_data is never asserted in a cycle where tx_busy is high.
- Reset mid-packet returns to IDLE immediately, no further new_req. An in-flight register write already strobed is not retracted.
- Throughput: a write burst issues one request per received byte. A read burst costs at least READ_LATENCY+2 cycles per byte, plus the tx_busy stall.

Optional Feature:
- Macro: UART_REG_TIMEOUT_EN.
- Defined:
  - A counter clears on every new_rx_data and on each state entry.
  - In COUNT or WDATA, reaching TIMEOUT_CYCLES-1 forces IDLE with no request issued for the missing bytes.
  - Read states are exempt.
- Undefined: no counter; the bridge waits indefinitely for packet bytes.

Decomposition:
- Package uart_reg_pkg holds:
  - state enum (IDLE, COUNT, WDATA, RREQ, RWAIT, RSEND);
  - header bit positions: HDR_WR=7, HDR_INC=6, HDR_ADDR=5:0;
  - REG_ADDR_W=6 and BURST_W=9.
- Optional sub-module: uart_reg_timeout (the timeout counter), instantiated only under UART_REG_TIMEOUT_EN. All other logic stays in one module.

Test Plan:
- Write burst: bytes 0xC8,0x02,0x10,0x20,0x30 -> three new_req writes, at addresses 0x08, 0x09, 0x0A with values 0x10, 0x20, 0x30; busy low afterwards.
- Read with no increment: 0x09,0x01, model returns 0x5A at READ_LATENCY=1 -> two new_req reads at 0x09; tx sees 0x5A,0x5A.
- Wrap-around: 0xFF,0x01,0xAA,0xBB -> writes at 0x3F then 0x00.
- tx_busy stall: read burst of 4 with tx_busy held high for 100 cycles after the first byte -> no new_tx_data during the stall, all 4 bytes sent in order, no extra new_req.
- Reset mid-burst: reset pulsed after the second of four write data bytes -> no further new_req; a following packet 0x80,0x00,0x77 writes 0x77 to 0x00.
- Timeout (with UART_REG_TIMEOUT_EN, TIMEOUT_CYCLES=100): header 0x81 then silence for 100 cycles -> bridge returns to IDLE, no new_req; the next byte is treated as a header.
